alu_resp_deser: RTL and testbench
=================================

ALU_RESP_DESER -- requirements
Module: alu_resp_deser

Interface
REQ-001 Parameter: CNT_W, 8, width of drop_cnt.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ser_in  input  1  serial response bit from the ALU dout, MSB first.
REQ-005 ser_valid  input  1  ALU dout_valid; each clk edge with ser_valid=1 carries one bit.
REQ-006 resp_ready  input  1  consumer accepts the response when resp_ready=1 and resp_valid=1.
REQ-007 resp_valid  output  1  response held in output register.
REQ-008 resp_status  output  8  payload of word 0 (ALU status).
REQ-009 resp_data  output  16  {word1 payload, word2 payload} (result high byte, low byte).
REQ-010 resp_short  output  1  status-only frame (10 bits).
REQ-011 err_parity  output  3  bit k=1: parity failure in word k.
REQ-012 err_ctl  output  3  bit k=1: control bit wrong in word k.
REQ-013 err_trunc  output  1  frame ended at an illegal bit count.
REQ-014 drop_cnt  output  CNT_W  count of responses lost to overrun, saturating.

Function
REQ-015 Word format SHALL be [9]=control (1 status, 0 data), [8:1]=payload, [0]=parity; a word is parity-good iff XOR of all 10 bits = 0 (e.g. 0x201, 0x300 good).
REQ-016 Full frame SHALL be 30 consecutive valid bits: word0 status (ctl=1), word1 result[15:8] (ctl=0), word2 result[7:0] (ctl=0).
REQ-017 FSM SHALL have states SYNC, IDLE, SHIFT.
REQ-018 SYNC: ignore ser_valid; go to IDLE on the first edge sampling ser_valid=0.
REQ-019 IDLE: on ser_valid=1, capture bit 1, bit_cnt=1, go to SHIFT.
REQ-020 SHIFT: each ser_valid=1 edge shifts ser_in into a 30-bit shift register, bit_cnt increments.
REQ-021 On the edge capturing bit 30, the frame SHALL close and the response load on that same edge; bit_cnt clears; if ser_valid remains 1 the next bit starts a new frame (back-to-back, no idle cycle).
REQ-022 In SHIFT, ser_valid=0 with bit_cnt=10 SHALL close a status-only frame: resp_short=1, resp_data=0, err_parity[2:1]=0, err_ctl[2:1]=0.
REQ-023 In SHIFT, ser_valid=0 with bit_cnt not 10 SHALL close a truncated frame: err_trunc=1, resp_status=0, resp_data=0, other error bits 0.
REQ-024 err_ctl[0]=1 iff word0[9]=0; err_ctl[k]=1 (k=1,2) iff wordk[9]=1; err_parity[k]=1 iff word k parity-bad.
REQ-025 Closed frames SHALL be delivered regardless of errors; errors are reported, not filtered.
REQ-026 Output register SHALL hold all resp_* and err_* stable while resp_valid=1 and resp_ready=0.
REQ-027 resp_valid SHALL clear on the edge where resp_valid=1 and resp_ready=1 unless a frame closes on that same edge, in which case the new response loads and resp_valid stays 1.
REQ-028 Frame closing while resp_valid=1 and resp_ready=0 SHALL be discarded, output unchanged, drop_cnt increments, saturating at 2^CNT_W-1.
REQ-029 Latency: resp_valid high in the cycle after the edge sampling bit 30 (full) or the first ser_valid=0 (short/truncated).
REQ-030 Only the listed states; no combinational path from ser_in/ser_valid to any output.

Reset
REQ-031 rst_n=0 at an edge SHALL set: FSM=SYNC, bit_cnt=0, shift register=0, resp_valid=0, resp_status=0, resp_data=0, resp_short=0, err_parity=0, err_ctl=0, err_trunc=0, drop_cnt=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; no response produced for it.
REQ-033 ser_valid=1 at reset release SHALL be ignored until sampled 0 once (SYNC).

Verification
REQ-034 Full frame 0x201,0x000+par,0x1FE (result 0x00FF... data words 0x000,0x1FE), resp_ready=1 -> resp_valid 1 cycle, status=0x00, data=0x00FF, all errors 0.
REQ-035 Short frame 0x300 then ser_valid=0 -> resp_short=1, status=0x80, data=0x0000, err_parity=0, err_ctl=0.
REQ-036 Valid drops after 17 bits -> err_trunc=1, status=0, data=0; next 30-bit frame decodes correctly.
REQ-037 Word1 with flipped parity bit and word2 ctl=1 -> err_parity=3'b010, err_ctl=3'b100, response still delivered.
REQ-038 resp_ready=0, three back-to-back full frames -> first held unchanged, drop_cnt=2; raise resp_ready on the edge a frame closes -> new frame loads, resp_valid stays 1, no drop.
REQ-039 rst_n=0 after 12 bits with ser_valid held 1 across release -> no response until ser_valid low then a fresh frame; all outputs 0 during/after reset.

Source files
------------

// File: rtl/alu_resp_deser.sv
// Deserialises the ALU's MSB-first response stream into status/result frames and
// presents each closed frame on a valid/ready output register, counting overruns.
module alu_resp_deser #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             resp_ready,
  output logic             resp_valid,
  output logic [7:0]       resp_status,
  output logic [15:0]      resp_data,
  output logic             resp_short,
  output logic [2:0]       err_parity,
  output logic [2:0]       err_ctl,
  output logic             err_trunc,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a response transfers on any edge where resp_valid=1 and resp_ready=1;
  // while resp_valid=1 and resp_ready=0 every resp_*/err_* output is held stable.

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [4:0]  bit_cnt;
  // Only 29 bits are stored: the 30th bit completes the frame combinationally.
  logic [28:0] sh;
  logic [29:0] frame;
  logic        close;
  logic [9:0]  w0, w1, w2;
  logic [7:0]  n_status;
  logic [15:0] n_data;
  logic        n_short;
  logic [2:0]  n_parity;
  logic [2:0]  n_ctl;
  logic        n_trunc;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      SYNC:    if (!ser_valid) state_d = IDLE;
      IDLE:    if (ser_valid) state_d = SHIFT;
      SHIFT:   if (!ser_valid || bit_cnt == 5'd29) state_d = IDLE;
      default: state_d = SYNC;
    endcase
  end

  // Frame-close decode: full frame on bit 30, short/truncated on the first gap.
  always_comb begin
    frame    = {sh, ser_in};
    close    = 1'b0;
    w0       = '0;
    w1       = '0;
    w2       = '0;
    n_status = '0;
    n_data   = '0;
    n_short  = 1'b0;
    n_parity = '0;
    n_ctl    = '0;
    n_trunc  = 1'b0;
    if (state == SHIFT) begin
      if (ser_valid && bit_cnt == 5'd29) begin
        close    = 1'b1;
        w0       = frame[29:20];
        w1       = frame[19:10];
        w2       = frame[9:0];
        n_status = w0[8:1];
        n_data   = {w1[8:1], w2[8:1]};
        n_parity = {^w2, ^w1, ^w0};
        n_ctl    = {w2[9], w1[9], ~w0[9]};
      end else if (!ser_valid) begin
        close = 1'b1;
        if (bit_cnt == 5'd10) begin
          w0       = sh[9:0];
          n_status = w0[8:1];
          n_short  = 1'b1;
          n_parity = {2'b00, ^w0};
          n_ctl    = {2'b00, ~w0[9]};
        end else begin
          n_trunc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      sh          <= '0;
      resp_valid  <= 1'b0;
      resp_status <= '0;
      resp_data   <= '0;
      resp_short  <= 1'b0;
      err_parity  <= '0;
      err_ctl     <= '0;
      err_trunc   <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ser_valid) begin
            sh      <= {28'd0, ser_in};
            bit_cnt <= 5'd1;
          end
        end
        SHIFT: begin
          if (ser_valid) begin
            sh      <= frame[28:0];
            bit_cnt <= (bit_cnt == 5'd29) ? 5'd0 : bit_cnt + 5'd1;
          end else begin
            bit_cnt <= 5'd0;
          end
        end
        default: ;
      endcase

      if (close) begin
        if (!resp_valid || resp_ready) begin
          resp_valid  <= 1'b1;
          resp_status <= n_status;
          resp_data   <= n_data;
          resp_short  <= n_short;
          err_parity  <= n_parity;
          err_ctl     <= n_ctl;
          err_trunc   <= n_trunc;
        end else if (drop_cnt != {CNT_W{1'b1}}) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_resp_deser.sv
// Directed bench for alu_resp_deser: a frame-level model predicts every response,
// a per-cycle compare process checks the DUT, and literal checks pin the model.
module tb_alu_resp_deser;

  typedef struct packed {
    logic [7:0]  sts;
    logic [15:0] dat;
    logic        shrt;
    logic [2:0]  par;
    logic [2:0]  ctl;
    logic        trn;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        ser_in;
  logic        ser_valid;
  logic        resp_ready;
  logic        resp_valid;
  logic [7:0]  resp_status;
  logic [15:0] resp_data;
  logic        resp_short;
  logic [2:0]  err_parity;
  logic [2:0]  err_ctl;
  logic        err_trunc;
  logic [7:0]  drop_cnt;
  logic [1:0]  dbg_state;
  resp_t       dut_resp;

  int checks = 0;
  int errors = 0;

  // Model state
  logic        chk_en = 1'b0;
  logic        m_close = 1'b0;
  resp_t       m_resp = '0;
  logic        exp_valid;
  logic [7:0]  exp_drop;
  resp_t       exp_resp;

  // Driver bookkeeping
  logic        rdy_drv = 1'b1;
  logic        sync_mode = 1'b1;
  int          cur_n = 0;
  logic [29:0] cur_bits = '0;

  alu_resp_deser #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .resp_ready (resp_ready),
    .resp_valid (resp_valid),
    .resp_status(resp_status),
    .resp_data  (resp_data),
    .resp_short (resp_short),
    .err_parity (err_parity),
    .err_ctl    (err_ctl),
    .err_trunc  (err_trunc),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  assign dut_resp = {resp_status, resp_data, resp_short, err_parity, err_ctl, err_trunc};

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n      = 1'b0;
    ser_in     = 1'b0;
    ser_valid  = 1'b0;
    resp_ready = 1'b1;
  end

  // Spec-level helpers
  function automatic logic [9:0] mk_word(input logic ctl, input logic [7:0] pl);
    return {ctl, pl, ^{ctl, pl}};
  endfunction

  function automatic resp_t mk_resp(input logic [7:0] s, input logic [15:0] d, input logic sh,
                                    input logic [2:0] p, input logic [2:0] c, input logic t);
    resp_t r;
    r.sts = s; r.dat = d; r.shrt = sh; r.par = p; r.ctl = c; r.trn = t;
    return r;
  endfunction

  function automatic resp_t dec_full(input logic [29:0] f);
    logic [9:0] a, b, c;
    a = f[29:20]; b = f[19:10]; c = f[9:0];
    return mk_resp(a[8:1], {b[8:1], c[8:1]}, 1'b0,
                   {^c, ^b, ^a}, {c[9], b[9], ~a[9]}, 1'b0);
  endfunction

  function automatic resp_t dec_part(input logic [29:0] f, input int n);
    logic [9:0] a;
    a = f[9:0];
    if (n == 10) return mk_resp(a[8:1], 16'h0000, 1'b1, {2'b00, ^a}, {2'b00, ~a[9]}, 1'b0);
    return mk_resp(8'h00, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b1);
  endfunction

  // Behavioural output-register model
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_drop  <= 8'd0;
      exp_resp  <= '0;
    end else if (m_close) begin
      if (!exp_valid || resp_ready) begin
        exp_valid <= 1'b1;
        exp_resp  <= m_resp;
      end else if (exp_drop != 8'hFF) begin
        exp_drop <= exp_drop + 8'd1;
      end
    end else if (exp_valid && resp_ready) begin
      exp_valid <= 1'b0;
    end
  end

  // Scoreboard compare, every cycle
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      checks++;
      if (resp_valid !== exp_valid || drop_cnt !== exp_drop) begin
        errors++;
        $display("FAIL handshake t=%0t: valid=%0b drop=%0d, expected valid=%0b drop=%0d",
                 $time, resp_valid, drop_cnt, exp_valid, exp_drop);
      end
      if (exp_valid) begin
        checks++;
        if (dut_resp !== exp_resp) begin
          errors++;
          $display("FAIL payload t=%0t: got %h, expected %h", $time, dut_resp, exp_resp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_bit(input logic v, input logic b);
    resp_t r;
    logic  cl;
    r  = '0;
    cl = 1'b0;
    @(negedge clk);
    ser_valid  = v;
    ser_in     = b;
    resp_ready = rdy_drv;
    if (sync_mode) begin
      if (!v) sync_mode = 1'b0;
    end else if (v) begin
      cur_bits = {cur_bits[28:0], b};
      cur_n++;
      if (cur_n == 30) begin
        cl    = 1'b1;
        r     = dec_full(cur_bits);
        cur_n = 0;
      end
    end else if (cur_n > 0) begin
      cl    = 1'b1;
      r     = dec_part(cur_bits, cur_n);
      cur_n = 0;
    end
    m_close = cl;
    m_resp  = r;
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) drive_bit(1'b1, w[i]);
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [7:0] hi, input logic [7:0] lo);
    send_word(mk_word(1'b1, s));
    send_word(mk_word(1'b0, hi));
    send_word(mk_word(1'b0, lo));
  endtask

  task automatic do_reset(input logic v_hold, input int n);
    @(negedge clk);
    rst_n     = 1'b0;
    ser_valid = v_hold;
    ser_in    = 1'b0;
    m_close   = 1'b0;
    cur_n     = 0;
    sync_mode = 1'b1;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_resp"}, dut_resp, 32'h0);
    chk({name, "_valid_drop"}, {23'd0, resp_valid, drop_cnt}, 32'h0);
  endtask

  logic [9:0] w1_bad, w2_bad;

  initial begin
    // Model pins: hand-computed decodes
    chk("model_word_201", {22'd0, mk_word(1'b1, 8'h00)}, 32'h201);
    chk("model_word_300", {22'd0, mk_word(1'b1, 8'h80)}, 32'h300);
    chk("model_full", dec_full({10'h201, 10'h000, 10'h1FE}),
        mk_resp(8'h00, 16'h00FF, 1'b0, 3'b000, 3'b000, 1'b0));
    chk("model_short", dec_part({20'd0, 10'h300}, 10),
        mk_resp(8'h80, 16'h0000, 1'b1, 3'b000, 3'b000, 1'b0));

    do_reset(1'b0, 3);
    chk_en = 1'b1;
    chk_all_zero("reset");
    drive_bit(1'b0, 1'b0);

    // Basic full frame, consumer ready
    rdy_drv = 1'b1;
    send_word(10'h201); send_word(10'h000); send_word(10'h1FE);
    drive_bit(1'b0, 1'b0);
    chk("full_resp", dut_resp, mk_resp(8'h00, 16'h00FF, 1'b0, 3'b000, 3'b000, 1'b0));
    chk("full_valid", {31'd0, resp_valid}, 32'd1);
    drive_bit(1'b0, 1'b0);
    chk("full_consumed", {31'd0, resp_valid}, 32'd0);

    // Status-only frame
    send_word(10'h300);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    chk("short_resp", dut_resp, mk_resp(8'h80, 16'h0000, 1'b1, 3'b000, 3'b000, 1'b0));

    // Truncated after 17 bits, then a good frame
    send_word(mk_word(1'b1, 8'h42));
    begin
      logic [9:0] wt;
      wt = mk_word(1'b0, 8'h99);
      for (int i = 9; i >= 3; i--) drive_bit(1'b1, wt[i]);
    end
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    chk("trunc_resp", dut_resp, mk_resp(8'h00, 16'h0000, 1'b0, 3'b000, 3'b000, 1'b1));
    send_frame(8'h5A, 8'h12, 8'h34);
    drive_bit(1'b0, 1'b0);
    chk("after_trunc_resp", dut_resp, mk_resp(8'h5A, 16'h1234, 1'b0, 3'b000, 3'b000, 1'b0));

    // Parity error in word1, control error in word2
    w1_bad = mk_word(1'b0, 8'hAB) ^ 10'h001;
    w2_bad = mk_word(1'b1, 8'hCD);
    send_word(mk_word(1'b1, 8'h01)); send_word(w1_bad); send_word(w2_bad);
    drive_bit(1'b0, 1'b0);
    chk("err_resp", dut_resp, mk_resp(8'h01, 16'hABCD, 1'b0, 3'b010, 3'b100, 1'b0));
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);

    // Overrun: three back-to-back frames with consumer stalled
    rdy_drv = 1'b0;
    send_frame(8'h11, 8'h22, 8'h33);
    send_frame(8'h44, 8'h55, 8'h66);
    send_frame(8'h77, 8'h88, 8'h99);
    drive_bit(1'b0, 1'b0);
    chk("overrun_held", dut_resp, mk_resp(8'h11, 16'h2233, 1'b0, 3'b000, 3'b000, 1'b0));
    chk("overrun_drop", {23'd0, resp_valid, drop_cnt}, {23'd0, 1'b1, 8'd2});
    // Ready rises on the very edge the next frame closes
    send_word(mk_word(1'b1, 8'hA1));
    send_word(mk_word(1'b0, 8'hB2));
    begin
      logic [9:0] wl;
      wl = mk_word(1'b0, 8'hC3);
      for (int i = 9; i >= 1; i--) drive_bit(1'b1, wl[i]);
      rdy_drv = 1'b1;
      drive_bit(1'b1, wl[0]);
    end
    drive_bit(1'b0, 1'b0);
    chk("swap_resp", dut_resp, mk_resp(8'hA1, 16'hB2C3, 1'b0, 3'b000, 3'b000, 1'b0));
    chk("swap_valid_drop", {23'd0, resp_valid, drop_cnt}, {23'd0, 1'b1, 8'd2});
    drive_bit(1'b0, 1'b0);

    // Drop counter saturation
    rdy_drv = 1'b0;
    for (int k = 0; k < 258; k++) send_frame(k[7:0], 8'h0F, 8'hF0);
    drive_bit(1'b0, 1'b0);
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
    rdy_drv = 1'b1;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);

    // Reset mid-frame with ser_valid held across release
    send_word(mk_word(1'b1, 8'h55));
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    do_reset(1'b1, 2);
    chk_all_zero("midreset");
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    chk("sync_ignore_valid", {31'd0, resp_valid}, 32'd0);
    drive_bit(1'b0, 1'b0);
    send_frame(8'h66, 8'h77, 8'h88);
    drive_bit(1'b0, 1'b0);
    chk("post_reset_resp", dut_resp, mk_resp(8'h66, 16'h7788, 1'b0, 3'b000, 3'b000, 1'b0));
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
